// File: rtl/sa_matrix_streamer.sv
// sa_matrix_streamer: buffers host A/B, streams them into the systolic array and captures the C rows it returns
module sa_matrix_streamer #(
  parameter int DATAWIDTH = 8,
  parameter int N_SIZE = 3,
  parameter int TIMEOUT = 4*N_SIZE+4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_en,
  input  logic wr_sel,
  input  logic [$clog2(N_SIZE)-1:0] wr_row,
  input  logic [$clog2(N_SIZE)-1:0] wr_col,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic start,
  output logic busy,
  output logic done,
  output logic error,
  input  logic [$clog2(N_SIZE)-1:0] rd_row,
  input  logic [$clog2(N_SIZE)-1:0] rd_col,
  output logic [2*DATAWIDTH-1:0] rd_data,
  output logic sa_valid_in,
  output logic [N_SIZE*DATAWIDTH-1:0] sa_a_out,
  output logic [N_SIZE*DATAWIDTH-1:0] sa_b_out,
  input  logic sa_valid_out,
  input  logic [N_SIZE*2*DATAWIDTH-1:0] sa_c_in
);
  localparam int IW = $clog2(N_SIZE);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam logic [IW:0] NL = (IW+1)'(N_SIZE);
  localparam logic [IW:0] NL1 = (IW+1)'(N_SIZE-1);
  localparam logic [IW-1:0] KL = IW'(N_SIZE-1);
  localparam logic [TW-1:0] TL1 = TW'(TIMEOUT-1);
  typedef enum logic [1:0] {IDLE, FEED, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [DATAWIDTH-1:0] a [N_SIZE][N_SIZE];
  logic [DATAWIDTH-1:0] b [N_SIZE][N_SIZE];
  logic [DATAWIDTH-1:0] a_nx [N_SIZE][N_SIZE];
  logic [DATAWIDTH-1:0] b_nx [N_SIZE][N_SIZE];
  logic [2*DATAWIDTH-1:0] c [N_SIZE][N_SIZE];
  logic [IW-1:0] k, kp;
  logic [IW:0] r;
  logic [TW-1:0] t;
  logic host, wr_ok, go, cap, to, beat;
  logic [N_SIZE*DATAWIDTH-1:0] a_beat, b_beat;

  assign busy = state == FEED || state == WAIT;
  assign done = state == DONE;
  assign host = state == IDLE || state == DONE;
  assign wr_ok = wr_en && host && {1'b0, wr_row} < NL && {1'b0, wr_col} < NL;
  assign go = start && host;
  assign cap = busy && sa_valid_out && r < NL;
  assign to = busy && r != NL && t == TL1 && !(cap && r == NL1);
  assign kp = k + 1'b1;
  assign beat = go || (state == FEED && state_nx == FEED);
  assign rd_data = ({1'b0, rd_row} < NL && {1'b0, rd_col} < NL) ? c[rd_row][rd_col] : '0;

  always_comb begin
    state_nx = go ? FEED : (busy && (r == NL || to)) ? DONE : (state == FEED && k == KL) ? WAIT : state;
  end

  always_comb begin
    a_nx = a;
    b_nx = b;
    a_beat = '0;
    b_beat = '0;
    if (wr_ok && !wr_sel) a_nx[wr_row][wr_col] = wr_data;
    if (wr_ok && wr_sel) b_nx[wr_row][wr_col] = wr_data;
    for (int i = 0; i < N_SIZE; i++) begin
      a_beat[i*DATAWIDTH +: DATAWIDTH] = go ? a_nx[i][0] : a[i][kp];
      b_beat[i*DATAWIDTH +: DATAWIDTH] = go ? b_nx[0][i] : b[kp][i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a <= '{default: '0};
      b <= '{default: '0};
      c <= '{default: '0};
      k <= '0;
      r <= '0;
      t <= '0;
      error <= 1'b0;
      sa_valid_in <= 1'b0;
      sa_a_out <= '0;
      sa_b_out <= '0;
    end else begin
      state <= state_nx;
      a <= a_nx;
      b <= b_nx;
      k <= go ? '0 : state == FEED ? kp : k;
      r <= go ? '0 : cap ? r + 1'b1 : r;
      t <= go ? '0 : busy ? t + 1'b1 : t;
      error <= go ? 1'b0 : to ? 1'b1 : error;
      sa_valid_in <= beat;
      sa_a_out <= beat ? a_beat : '0;
      sa_b_out <= beat ? b_beat : '0;
      if (go) c <= '{default: '0};
      else if (cap)
        for (int m = 0; m < N_SIZE; m++) c[r[IW-1:0]][m] <= sa_c_in[m*2*DATAWIDTH +: 2*DATAWIDTH];
    end
  end
endmodule

// File: tb/tb_sa_matrix_streamer.sv
// tb_sa_matrix_streamer: model-checked directed test of the streamer driving a behavioural systolic array stub
module tb_sa_matrix_streamer;
  localparam int N = 3;
  localparam int DW = 8;
  localparam int TO = 4*N+4;
  typedef int mat_t [N][N];
  logic clk = 0, rst_n = 0, wr_en = 0, wr_sel = 0, start = 0;
  logic [1:0] wr_row = 0, wr_col = 0, rd_row = 0, rd_col = 0;
  logic [DW-1:0] wr_data = 0;
  logic busy, done, error, sa_valid_in;
  logic sa_valid_out = 0;
  logic [2*DW-1:0] rd_data;
  logic [N*DW-1:0] sa_a_out, sa_b_out;
  logic [N*2*DW-1:0] sa_c_in = 0;
  int n_chk = 0, n_pass = 0;
  int stub_max = N;
  bit stray = 0;
  int fa [N][N];
  int fb [N][N];
  int nb = 0, er = -1;
  int mA [N][N];
  int mB [N][N];
  int mC [N][N];
  bit run = 0, fin = 0, err = 0;
  int n = 0, rows = 0, full_at = -1;

  sa_matrix_streamer #(.DATAWIDTH(DW), .N_SIZE(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done), .error(error),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data), .sa_valid_in(sa_valid_in),
    .sa_a_out(sa_a_out), .sa_b_out(sa_b_out), .sa_valid_out(sa_valid_out), .sa_c_in(sa_c_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, want);
  endtask

  // array stub: collects the fed beats, then returns rows of A*B one per cycle
  initial begin
    int ri, s;
    forever begin
      @(negedge clk);
      sa_valid_out = 0;
      sa_c_in = '0;
      if (!rst_n) begin
        nb = 0;
        er = -1;
      end else if (stray) begin
        sa_valid_out = 1;
        sa_c_in = {N{16'hbeef}};
      end else if (sa_valid_in) begin
        for (int i = 0; i < N; i++) begin
          fa[i][nb] = int'(sa_a_out[i*DW +: DW]);
          fb[nb][i] = int'(sa_b_out[i*DW +: DW]);
        end
        nb++;
        if (nb == N) begin
          nb = 0;
          er = 0;
        end
      end else if (er >= 0 && er < stub_max) begin
        ri = er % N;
        for (int m = 0; m < N; m++) begin
          s = 0;
          for (int q = 0; q < N; q++) s += fa[ri][q] * fb[q][m];
          sa_c_in[m*2*DW +: 2*DW] = 16'(s);
        end
        sa_valid_out = 1;
        er++;
        if (er == stub_max) er = -1;
      end
    end
  end

  // reference model: n is the cycle index counted from the first feed beat
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mA = '{default: 0};
      mB = '{default: 0};
      mC = '{default: 0};
      run = 0;
      fin = 0;
      err = 0;
    end else if (!run) begin
      if (wr_en && wr_row < N && wr_col < N) begin
        if (wr_sel) mB[wr_row][wr_col] = int'(wr_data);
        else mA[wr_row][wr_col] = int'(wr_data);
      end
      if (start) begin
        run = 1;
        fin = 0;
        err = 0;
        n = 0;
        rows = 0;
        full_at = -1;
        mC = '{default: 0};
      end
    end else begin
      if (sa_valid_out && rows < N) begin
        for (int m = 0; m < N; m++) mC[rows][m] = int'(sa_c_in[m*2*DW +: 2*DW]);
        rows++;
        if (rows == N) full_at = n;
      end
      if (full_at >= 0 && n == full_at + 1) begin
        run = 0;
        fin = 1;
      end else if (rows < N && n == TO - 1) begin
        run = 0;
        fin = 1;
        err = 1;
      end
      n++;
    end
  end

  initial forever begin
    logic [N*DW-1:0] ea, eb;
    bit ev;
    @(negedge clk);
    #1;
    ev = run && n < N;
    ea = '0;
    eb = '0;
    if (ev)
      for (int i = 0; i < N; i++) begin
        ea[i*DW +: DW] = DW'(mA[i][n]);
        eb[i*DW +: DW] = DW'(mB[n][i]);
      end
    chk("m_busy", busy, run);
    chk("m_done", done, fin);
    chk("m_error", error, err);
    chk("m_valid_in", sa_valid_in, ev);
    chk("m_a_out", sa_a_out, ea);
    chk("m_b_out", sa_b_out, eb);
    chk("m_rd_data", rd_data, (rd_row < N && rd_col < N) ? mC[rd_row][rd_col] : 0);
  end

  task automatic wr(input bit s, input int r, input int c, input int d);
    @(negedge clk);
    wr_en = 1;
    wr_sel = s;
    wr_row = 2'(r);
    wr_col = 2'(c);
    wr_data = DW'(d);
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic load(input bit s, input mat_t m);
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) wr(s, r, c, m[r][c]);
  endtask

  task automatic go();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input string nm);
    int c = 0;
    while (!done && c < 60) begin
      @(negedge clk);
      c++;
    end
    chk(nm, done, 1);
  endtask

  task automatic rd_chk(input string nm, input int r, input int c, input int want);
    @(negedge clk);
    rd_row = 2'(r);
    rd_col = 2'(c);
    #1;
    chk(nm, rd_data, want);
  endtask

  task automatic rd_mat(input string nm, input mat_t e);
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) rd_chk(nm, r, c, e[r][c]);
  endtask

  initial begin
    mat_t ma, mi, id, sq, tc, zr;
    int cyc;
    ma = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    mi = '{'{9, 8, 7}, '{6, 5, 4}, '{3, 2, 1}};
    id = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};
    sq = '{'{30, 36, 42}, '{66, 81, 96}, '{102, 126, 150}};
    tc = '{'{30, 36, 42}, '{66, 81, 96}, '{0, 0, 0}};
    zr = '{default: 0};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_valid", sa_valid_in, 0);
    chk("rst_rd", rd_data, 0);
    rst_n = 1;
    load(0, ma);
    load(1, ma);
    go();
    #1;
    chk("feed_a0", sa_a_out, 24'h070401);
    chk("feed_b0", sa_b_out, 24'h030201);
    @(negedge clk);
    #1;
    chk("feed_a1", sa_a_out, 24'h080502);
    chk("feed_b1", sa_b_out, 24'h060504);
    @(negedge clk);
    #1;
    chk("feed_a2", sa_a_out, 24'h090603);
    chk("feed_b2", sa_b_out, 24'h090807);
    @(negedge clk);
    #1;
    chk("feed_end_v", sa_valid_in, 0);
    chk("feed_end_a", sa_a_out, 0);
    wait_done("e2e_done");
    chk("e2e_error", error, 0);
    rd_mat("e2e_c", sq);
    go();
    wr_en = 1;
    wr_sel = 0;
    wr_row = 0;
    wr_col = 0;
    wr_data = 99;
    start = 1;
    @(negedge clk);
    wr_en = 0;
    start = 0;
    wait_done("busy_done");
    rd_mat("busy_c", sq);
    load(0, mi);
    load(1, id);
    go();
    wait_done("id_done");
    rd_mat("id_c", mi);
    stub_max = N + 1;
    go();
    wait_done("id2_done");
    rd_mat("id2_c", mi);
    stub_max = N;
    wr(0, 3, 0, 55);
    rd_chk("oob_rd", 3, 1, 0);
    load(0, ma);
    load(1, ma);
    stub_max = 2;
    go();
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("to_latency", cyc, 16);
    chk("to_error", error, 1);
    rd_mat("to_c", tc);
    stub_max = N;
    rd_chk("pre_go_rd", 0, 0, 30);
    go();
    repeat (4) @(negedge clk);
    #1;
    chk("wait_rd", rd_data, 30);
    rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_valid", sa_valid_in, 0);
    chk("arst_rd", rd_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    stray = 1;
    repeat (4) @(negedge clk);
    stray = 0;
    rd_mat("stray_c", zr);
    chk("stray_done", done, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
